vga_scan_timing_gen: RTL

- Pixel-scan timing source for the 640x480@60 display path. It generates DrawX, DrawY and blank, which the sprite mapper/ROM/palette blocks consume, plus the hs/vs monitor syncs.
- It also carries a per-frame sprite animation sequencer. Running-animation mappers use anim_frame to select which frame ROM to display.
- Sits between the 25 MHz vga_clk domain and every DrawX/DrawY consumer.

---
 rtl/vga_scan_timing_gen.sv | 105 ++++++++++
 1 files changed

// File: rtl/vga_scan_timing_gen.sv
// 640x480@60 pixel-scan timing source with a per-frame sprite animation sequencer.
// Every output is registered from the same next-(hc,vc), so DrawX/DrawY and all decodes stay aligned.
module vga_scan_timing_gen #(
  parameter int H_VISIBLE       = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_VISIBLE       = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter int ANIM_FRAMES     = 6,
  parameter int FRAMES_PER_STEP = 4
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       anim_enable,
  input  logic       anim_restart,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       frame_start,
  output logic       line_start,
  output logic [2:0] anim_frame,
  output logic       anim_step
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [3:0] FC_LAST = 4'(FRAMES_PER_STEP - 1);
  localparam logic [2:0] AF_LAST = 3'(ANIM_FRAMES - 1);

  logic [9:0] hc, vc, hc_nxt, vc_nxt;
  logic [3:0] fcnt, fcnt_nxt;
  logic [2:0] af_nxt;
  logic       fs_nxt, step_nxt;

  always_comb begin
    hc_nxt   = hc + 10'd1;
    vc_nxt   = vc;
    if (hc == H_LAST) begin
      hc_nxt = '0;
      vc_nxt = (vc == V_LAST) ? '0 : vc + 10'd1;
    end
    fs_nxt   = (hc_nxt == '0) && (vc_nxt == '0);

    // Animation only moves on the edge that loads (0,0); restart wins over a step.
    fcnt_nxt = fcnt;
    af_nxt   = anim_frame;
    step_nxt = 1'b0;
    if (anim_restart) begin
      fcnt_nxt = '0;
      af_nxt   = '0;
    end else if (fs_nxt && anim_enable) begin
      if (fcnt == FC_LAST) begin
        fcnt_nxt = '0;
        af_nxt   = (anim_frame == AF_LAST) ? 3'd0 : anim_frame + 3'd1;
        step_nxt = 1'b1;
      end else begin
        fcnt_nxt = fcnt + 4'd1;
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hc          <= H_LAST;
      vc          <= V_LAST;
      hs          <= 1'b1;
      vs          <= 1'b1;
      blank       <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      anim_step   <= 1'b0;
      anim_frame  <= '0;
      fcnt        <= '0;
    end else begin
      hc          <= hc_nxt;
      vc          <= vc_nxt;
      hs          <= !((hc_nxt >= HS_BEG) && (hc_nxt < HS_END));
      vs          <= !((vc_nxt >= VS_BEG) && (vc_nxt < VS_END));
      blank       <= (hc_nxt < H_VIS) && (vc_nxt < V_VIS);
      frame_start <= fs_nxt;
      line_start  <= (hc_nxt == '0);
      anim_step   <= step_nxt;
      anim_frame  <= af_nxt;
      fcnt        <= fcnt_nxt;
    end
  end

  assign DrawX = hc;
  assign DrawY = vc;

endmodule
